// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LOAD = 1'b1;

  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational grant, registered pointer.
// The lock input parks the pointer on the loader.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic c_req,
  input  logic l_req,
  input  logic lock,
  output logic gnt,
  output logic sel
);

  logic ptr;

  always_comb begin
    gnt = en & (c_req | l_req);
    sel = (c_req & l_req) ? ptr : l_req;
  end

  // A grant and a lock request never coincide: grants happen in IDLE, lock at BUSY exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= OWN_CORE;
    end else if (gnt) begin
      ptr <= ~sel;
    end else if (lock) begin
      ptr <= OWN_LOAD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the core (c_*) and the loader (l_*).
// Define MEM_ARB_LOCK_EN to add the l_lock burst-ownership input.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_ready,
`ifdef MEM_ARB_LOCK_EN
  input  logic              l_lock,
`endif
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              owner,
  output logic              err
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             gnt;
  logic             sel;
  logic             busy_done;
  logic             lock_set;

  always_comb begin
    busy_done = (state == BUSY) && (m_ready || (cnt == LAST));
`ifdef MEM_ARB_LOCK_EN
    lock_set  = busy_done && (owner == OWN_LOAD) && l_lock;
`else
    lock_set  = 1'b0;
`endif
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == IDLE),
    .c_req (c_req),
    .l_req (l_req),
    .lock  (lock_set),
    .gnt   (gnt),
    .sel   (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      owner   <= OWN_CORE;
      c_rdata <= '0;
      l_rdata <= '0;
      c_ready <= 1'b0;
      l_ready <= 1'b0;
      err     <= 1'b0;
    end else begin
      c_ready <= 1'b0;
      l_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt) begin
            owner <= sel;
            m_req <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
            if (sel == OWN_LOAD) begin
              m_we    <= l_we;
              m_addr  <= l_addr;
              m_wdata <= l_wdata;
            end else begin
              m_we    <= c_we;
              m_addr  <= c_addr;
              m_wdata <= c_wdata;
            end
          end
        end
        BUSY: begin
          if (busy_done) begin
            m_req <= 1'b0;
            err   <= ~m_ready;
            state <= RESP;
            // Writes and timeouts both return zero data.
            if (owner == OWN_LOAD) begin
              l_rdata <= (m_ready && !m_we) ? m_rdata : '0;
              l_ready <= 1'b1;
            end else begin
              c_rdata <= (m_ready && !m_we) ? m_rdata : '0;
              c_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (lock test when MEM_ARB_LOCK_EN is defined).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c_ready;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic [DW-1:0] l_rdata;
  logic          l_ready;
`ifdef MEM_ARB_LOCK_EN
  logic          l_lock = 1'b0;
`endif
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          owner, err;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ready(l_ready),
`ifdef MEM_ARB_LOCK_EN
    .l_lock(l_lock),
`endif
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .owner(owner), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the cycle where the request is presented; returns in the RESP cycle.
  // waitc = BUSY cycle in which memory answers (0 = never).
  task automatic serve(input int unsigned waitc, input logic [31:0] rd,
                       output int unsigned busy, output logic own, output logic we0,
                       output logic [31:0] a0, output logic [31:0] d0, output logic stable,
                       output logic gc, output logic gl, output logic ge);
    busy = 0; stable = 1'b1; own = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
    tick();
    while (m_req === 1'b1 && busy < 40) begin
      if (busy == 0) begin
        own = owner; we0 = m_we; a0 = m_addr; d0 = m_wdata;
      end else if (m_we !== we0 || m_addr !== a0 || m_wdata !== d0) begin
        stable = 1'b0;
      end
      busy++;
      if (busy == waitc) begin
        m_ready = 1'b1; m_rdata = rd;
      end else begin
        m_ready = 1'b0; m_rdata = 32'h0BAD_F00D;
      end
      tick();
    end
    m_ready = 1'b0;
    gc = c_ready; gl = l_ready; ge = err;
  endtask

  int unsigned busy;
  logic        own, we0, stable, gc, gl, ge;
  logic [31:0] a0, d0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    check("rst_m_req",   32'(m_req),   32'd0);
    check("rst_c_ready", 32'(c_ready), 32'd0);
    check("rst_l_ready", 32'(l_ready), 32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_owner",   32'(owner),   32'd0);
    check("rst_c_rdata", c_rdata,      32'd0);
    rst = 1'b0;
    tick();

    // Core read, memory answers in the third BUSY cycle.
    c_we = 1'b0; c_addr = 32'h100; c_req = 1'b1;
    serve(3, 32'hDEAD_BEEF, busy, own, we0, a0, d0, stable, gc, gl, ge);
    check("rd_busy",    busy,          32'd3);
    check("rd_owner",   32'(own),      32'd0);
    check("rd_addr",    a0,            32'h100);
    check("rd_we",      32'(we0),      32'd0);
    check("rd_c_ready", 32'(gc),       32'd1);
    check("rd_l_ready", 32'(gl),       32'd0);
    check("rd_c_rdata", c_rdata,       32'hDEAD_BEEF);
    c_req = 1'b0;
    tick();
    check("rd_ready_1cyc", 32'(c_ready), 32'd0);
    tick();
    check("rd_no_regrant", 32'(m_req), 32'd0);

    // Contention from reset: strict C, L, C, L.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    c_addr = 32'h200; l_addr = 32'h300; c_req = 1'b1; l_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'hA000_0000 + 32'(i), busy, own, we0, a0, d0, stable, gc, gl, ge);
      check($sformatf("rr%0d_owner", i),   32'(own),  32'(i % 2));
      check($sformatf("rr%0d_addr", i),    a0,        (i % 2 == 1) ? 32'h300 : 32'h200);
      check($sformatf("rr%0d_busy", i),    busy,      32'd1);
      check($sformatf("rr%0d_c_ready", i), 32'(gc),   32'(i % 2 == 0));
      check($sformatf("rr%0d_l_ready", i), 32'(gl),   32'(i % 2 == 1));
      if (i == 1) begin
        check("rr_c_rdata_hold", c_rdata, 32'hA000_0000);
        check("rr_l_rdata",      l_rdata, 32'hA000_0001);
      end
      if (i < 3) tick();
    end
    c_req = 1'b0; l_req = 1'b0;
    tick();

    // Loader write: read data returned by memory must not be captured.
    l_we = 1'b1; l_addr = 32'h40; l_wdata = 32'h1234_5678; l_req = 1'b1;
    serve(2, 32'hFFFF_FFFF, busy, own, we0, a0, d0, stable, gc, gl, ge);
    check("wr_we",      32'(we0),    32'd1);
    check("wr_addr",    a0,          32'h40);
    check("wr_wdata",   d0,          32'h1234_5678);
    check("wr_stable",  32'(stable), 32'd1);
    check("wr_owner",   32'(own),    32'd1);
    check("wr_l_ready", 32'(gl),     32'd1);
    check("wr_c_ready", 32'(gc),     32'd0);
    check("wr_l_rdata", l_rdata,     32'd0);
    l_req = 1'b0; l_we = 1'b0;
    tick();

    // Timeout with memory silent, then a normal transaction (c_req held).
    c_addr = 32'h80; c_req = 1'b1;
    serve(0, 32'h0, busy, own, we0, a0, d0, stable, gc, gl, ge);
    check("to_busy",    busy,     TO);
    check("to_err",     32'(ge),  32'd1);
    check("to_c_ready", 32'(gc),  32'd1);
    check("to_c_rdata", c_rdata,  32'd0);
    tick();
    check("to_err_1cyc", 32'(err), 32'd0);
    serve(2, 32'h55, busy, own, we0, a0, d0, stable, gc, gl, ge);
    check("post_to_busy",    busy,    32'd2);
    check("post_to_err",     32'(ge), 32'd0);
    check("post_to_c_ready", 32'(gc), 32'd1);
    check("post_to_c_rdata", c_rdata, 32'h55);
    c_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of BUSY.
    c_addr = 32'h10; c_req = 1'b1;
    tick(); tick();
    check("ar_pre_m_req", 32'(m_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_m_req",   32'(m_req),   32'd0);
    check("ar_c_ready", 32'(c_ready), 32'd0);
    check("ar_err",     32'(err),     32'd0);
    c_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    c_req = 1'b1; l_req = 1'b1;
    serve(1, 32'h77, busy, own, we0, a0, d0, stable, gc, gl, ge);
    check("ar_owner",   32'(own), 32'd0);
    check("ar_c_ready", 32'(gc),  32'd1);
    c_req = 1'b0; l_req = 1'b0;
    tick();

`ifdef MEM_ARB_LOCK_EN
    // Lock keeps the loader winning until released.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    l_lock = 1'b1; c_req = 1'b1; l_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) l_lock = 1'b0;
      serve(1, 32'hC000_0000 + 32'(i), busy, own, we0, a0, d0, stable, gc, gl, ge);
      check($sformatf("lock%0d_owner", i), 32'(own), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    c_req = 1'b0; l_req = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
